// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide sequencer.
// Op encoding follows the decoded funct field used by EX.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CALC  = 2'b01,
    FIXUP = 2'b10
  } md_state_t;

  localparam int MD_ITER  = 32;
  localparam int MD_CNT_W = $clog2(MD_ITER) + 1;

  function automatic logic md_is_div(input md_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(input md_op_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide on a 2*WIDTH accumulator.
// Multiply keeps {partial product, remaining multiplier}; divide keeps {remainder, dividend/quotient}.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_nx
);

  logic [WIDTH:0]   add_s;
  logic [WIDTH:0]   rem_sh_s;
  logic [WIDTH-1:0] diff_s;

  // Single-iteration datapath for both op classes
  always_comb begin
    add_s    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
    rem_sh_s = acc[2*WIDTH-1:WIDTH-1];
    // When the subtraction is taken the true difference is below the divisor, so WIDTH bits suffice
    diff_s   = rem_sh_s[WIDTH-1:0] - operand;
    acc_nx   = acc;
    if (is_div) begin
      if (rem_sh_s >= {1'b0, operand}) begin
        acc_nx = {diff_s, acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_nx = {rem_sh_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (acc[0]) begin
        acc_nx = {add_s, acc[WIDTH-1:1]};
      end else begin
        acc_nx = {1'b0, acc[2*WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the architectural HI/LO registers.
// Works on operand magnitudes and applies the sign fix in a final FIXUP cycle.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             hilo_rd,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             flush,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int AW = 2 * WIDTH;

  md_state_t             state_r, state_nx_s;
  md_op_t                op_s;
  logic [MD_CNT_W-1:0]   cnt_r;
  logic                  div_r, neg_res_r, neg_rem_r, dz_r;
  logic [WIDTH-1:0]      opnd_r;
  logic [AW-1:0]         acc_r, acc_nx_s;
  logic [WIDTH-1:0]      hi_r, lo_r;
  logic                  busy_r, done_r;

  logic                  accept_s, last_iter_s;
  logic                  is_div_s, is_signed_s, rs_neg_s, rt_neg_s, dz_s;
  logic [WIDTH-1:0]      rs_mag_s, rt_mag_s, acc_lo_init_s, opnd_init_s;
  logic [AW-1:0]         prod_s;
  logic [WIDTH-1:0]      quot_s, rem_s, hi_fix_s, lo_fix_s;

  assign op_s        = md_op_t'(op);
  assign accept_s    = start & ~busy_r & ~flush;
  assign last_iter_s = (cnt_r == MD_CNT_W'(MD_ITER - 1));
  assign stall       = busy_r & (start | hilo_rd | hi_we | lo_we);

  assign hi   = hi_r;
  assign lo   = lo_r;
  assign busy = busy_r;
  assign done = done_r;

  // Operand decode: magnitudes, sign flags and divide-by-zero detection at issue
  always_comb begin
    is_div_s    = md_is_div(op_s);
    is_signed_s = md_is_signed(op_s);
    rs_neg_s    = is_signed_s & rs_data[WIDTH-1];
    rt_neg_s    = is_signed_s & rt_data[WIDTH-1];
    rs_mag_s    = rs_neg_s ? (~rs_data + WIDTH'(1)) : rs_data;
    rt_mag_s    = rt_neg_s ? (~rt_data + WIDTH'(1)) : rt_data;
    dz_s        = is_div_s & (rt_data == '0);
    if (is_div_s) begin
      // A zero divisor shifts the raw dividend through into the remainder half
      acc_lo_init_s = dz_s ? rs_data : rs_mag_s;
      opnd_init_s   = rt_mag_s;
    end else begin
      acc_lo_init_s = rt_mag_s;
      opnd_init_s   = rs_mag_s;
    end
  end

  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .is_div  (div_r),
    .acc     (acc_r),
    .operand (opnd_r),
    .acc_nx  (acc_nx_s)
  );

  // Sign fix and HI/LO selection applied in FIXUP
  always_comb begin
    prod_s = neg_res_r ? (~acc_r + AW'(1)) : acc_r;
    quot_s = neg_res_r ? (~acc_r[WIDTH-1:0] + WIDTH'(1)) : acc_r[WIDTH-1:0];
    rem_s  = neg_rem_r ? (~acc_r[AW-1:WIDTH] + WIDTH'(1)) : acc_r[AW-1:WIDTH];
    if (!div_r) begin
      hi_fix_s = prod_s[AW-1:WIDTH];
      lo_fix_s = prod_s[WIDTH-1:0];
    end else if (dz_r) begin
      hi_fix_s = acc_r[AW-1:WIDTH];
      lo_fix_s = '1;
    end else begin
      hi_fix_s = rem_s;
      lo_fix_s = quot_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nx_s = CALC;
        end else begin
          state_nx_s = IDLE;
        end
      end
      CALC: begin
        if (flush) begin
          state_nx_s = IDLE;
        end else if (last_iter_s) begin
          state_nx_s = FIXUP;
        end else begin
          state_nx_s = CALC;
        end
      end
      FIXUP:   state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Datapath, counter and architectural HI/LO
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r     <= '0;
      div_r     <= 1'b0;
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
      dz_r      <= 1'b0;
      opnd_r    <= '0;
      acc_r     <= '0;
      hi_r      <= '0;
      lo_r      <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            div_r     <= is_div_s;
            neg_res_r <= rs_neg_s ^ rt_neg_s;
            neg_rem_r <= rs_neg_s;
            dz_r      <= dz_s;
            opnd_r    <= opnd_init_s;
            acc_r     <= {{WIDTH{1'b0}}, acc_lo_init_s};
            cnt_r     <= '0;
            busy_r    <= 1'b1;
          end else begin
            busy_r    <= 1'b0;
          end
          if (hi_we) begin
            hi_r <= wdata;
          end
          if (lo_we) begin
            lo_r <= wdata;
          end
        end
        CALC: begin
          if (flush) begin
            busy_r <= 1'b0;
          end else begin
            acc_r  <= acc_nx_s;
            cnt_r  <= cnt_r + MD_CNT_W'(1);
          end
        end
        FIXUP: begin
          if (flush) begin
            busy_r <= 1'b0;
          end else begin
            hi_r   <= hi_fix_s;
            lo_r   <= lo_fix_s;
            done_r <= 1'b1;
            busy_r <= 1'b0;
          end
        end
        default: busy_r <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed corner cases plus random ops
// compared against an arithmetic reference model.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, hilo_rd, hi_we, lo_we, flush;
  logic [1:0]  op;
  logic [31:0] rs_data, rt_data, wdata;
  logic [31:0] hi, lo;
  logic        busy, done, stall;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .hilo_rd (hilo_rd),
    .hi_we   (hi_we),
    .lo_we   (lo_we),
    .wdata   (wdata),
    .flush   (flush),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .done    (done),
    .stall   (stall)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Returns {HI, LO} as the architecture defines them.
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, q, m;
    logic [63:0] ua, ub, uq, um, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    r  = 64'd0;
    case (o)
      2'b00: r = sa * sb;
      2'b01: r = ua * ub;
      2'b10: begin
        if (b == 32'd0) begin
          r = {a, 32'hFFFF_FFFF};
        end else begin
          q = sa / sb;
          m = sa % sb;
          r = {m[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) begin
          r = {a, 32'hFFFF_FFFF};
        end else begin
          uq = ua / ub;
          um = ua % ub;
          r  = {um[31:0], uq[31:0]};
        end
      end
    endcase
    return r;
  endfunction

  // Called #1 after an edge; returns #1 after the accepting edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op      = o;
    rs_data = a;
    rt_data = b;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
  endtask

  // n0 = edges already elapsed since (and including) the accepting edge.
  task automatic wait_done(input string tag, input logic [63:0] exp, input int n0);
    int n;
    int nb;
    n  = n0;
    nb = 0;
    while (done !== 1'b1 && n < 80) begin
      if (busy === 1'b1) nb++;
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'd34);
    check({tag, "_busycyc"}, 32'(nb), 32'(34 - n0));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_hi"}, hi, exp[63:32]);
    check({tag, "_lo"}, lo, exp[31:0]);
  endtask

  initial begin
    int nd;
    reset_n = 1'b0;
    start   = 1'b0;
    hilo_rd = 1'b0;
    hi_we   = 1'b0;
    lo_we   = 1'b0;
    flush   = 1'b0;
    op      = 2'b00;
    rs_data = 32'd0;
    rt_data = 32'd0;
    wdata   = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    hilo_rd = 1'b1;
    #1;
    check("idle_nostall", 32'(stall), 32'd0);
    hilo_rd = 1'b0;
    @(posedge clk);
    #1;

    // Directed cases, several of them issued back-to-back in the done cycle
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu_max", 64'hFFFF_FFFE_0000_0001, 1);
    issue(MD_MULT, 32'hFFFF_FFFD, 32'd7);
    wait_done("mult_neg", 64'hFFFF_FFFF_FFFF_FFEB, 1);
    issue(MD_DIVU, 32'd100, 32'd7);
    wait_done("divu_b2b", {32'd2, 32'd14}, 1);
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_neg", 64'hFFFF_FFFF_FFFF_FFFD, 1);
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", 64'h0000_0000_8000_0000, 1);
    issue(MD_DIV, 32'h1234_5678, 32'd0);
    wait_done("div_zero", 64'h1234_5678_FFFF_FFFF, 1);

    for (int i = 0; i < 30; i++) begin
      logic [1:0]  o;
      logic [31:0] a, b;
      logic [63:0] e;
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'($urandom_range(0, 1000));
        default: ;
      endcase
      e = ref_model(o, a, b);
      issue(o, a, b);
      wait_done($sformatf("rnd%0d_op%0d", i, o), e, 1);
    end

    // Stall behaviour while busy; held MTHI and start both land after done
    issue(MD_MULTU, 32'h0001_2345, 32'h0001_0000);
    repeat (3) begin @(posedge clk); #1; end
    hilo_rd = 1'b1;
    #1;
    check("stall_rd", 32'(stall), 32'd1);
    hilo_rd = 1'b0;
    @(posedge clk);
    #1;
    hi_we = 1'b1;
    wdata = 32'hAAAA_5555;
    #1;
    check("stall_we", 32'(stall), 32'd1);
    @(posedge clk);
    #1;
    op      = MD_DIVU;
    rs_data = 32'd100;
    rt_data = 32'd7;
    start   = 1'b1;
    #1;
    check("stall_start", 32'(stall), 32'd1);
    wait_done("stl_mul", 64'h0000_0001_2345_0000, 6);
    check("stall_done_cyc", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    start = 1'b0;
    check("mthi_landed", hi, 32'hAAAA_5555);
    check("mthi_lo_kept", lo, 32'h2345_0000);
    check("held_start_acc", 32'(busy), 32'd1);
    wait_done("stl_divu", {32'd2, 32'd14}, 1);

    // Flush at iteration 10
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_done", 32'(done), 32'd0);
    check("flush_hi", hi, 32'd2);
    check("flush_lo", lo, 32'd14);
    nd = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) nd++;
    end
    check("flush_quiet", 32'(nd), 32'd0);

    // Flush in IDLE blocks acceptance
    op      = MD_MULT;
    rs_data = 32'd5;
    rt_data = 32'hFFFF_FFFA;
    start   = 1'b1;
    flush   = 1'b1;
    @(posedge clk);
    #1;
    check("flush_idle_block", 32'(busy), 32'd0);
    flush = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("flush_idle_acc", 64'hFFFF_FFFF_FFFF_FFE2, 1);

    // MTLO in IDLE
    lo_we = 1'b1;
    wdata = 32'h5A5A_1234;
    @(posedge clk);
    #1;
    lo_we = 1'b0;
    check("mtlo", lo, 32'h5A5A_1234);
    check("mtlo_hi_kept", hi, 32'hFFFF_FFFF);

    // Asynchronous reset at iteration 20, away from any clock edge
    issue(MD_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    repeat (19) begin @(posedge clk); #1; end
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    issue(MD_DIV, 32'h0000_1000, 32'hFFFF_FFF0);
    wait_done("post_rst", 64'h0000_0000_FFFF_FF00, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative multiply/divide sequencer for the MIPS pipeline's HI/LO unit. It accepts MULT, MULTU, DIV and DIVU from the EX stage and runs a 32-iteration shift-add multiply or restoring divide. It owns the architectural HI/LO registers and raises a stall to the hazard logic whenever the pipeline touches HI/LO or issues a new op while an operation is in flight. It sits beside the ALU and is sequenced by the same decoded funct field.

## Interface
- `WIDTH`, 32: operand width; HI/LO are `WIDTH` bits each.
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous active-low reset.
- `start` in 1: request a new operation; held by EX until accepted.
- `op` in 2: operation select, `MD_MULT`=00, `MD_MULTU`=01, `MD_DIV`=10, `MD_DIVU`=11.
- `rs_data` in WIDTH: multiplicand or dividend.
- `rt_data` in WIDTH: multiplier or divisor.
- `hilo_rd` in 1: MFHI/MFLO in EX.
- `hi_we`, `lo_we` in 1: MTHI/MTLO write strobes.
- `wdata` in WIDTH: MTHI/MTLO data.
- `flush` in 1: synchronous abort of the in-flight operation.
- `hi`, `lo` out WIDTH: architectural HI/LO, registered.
- `busy` out 1: operation in flight.
- `done` out 1: one-cycle completion pulse.
- `stall` out 1: combinational pipeline stall request.

## Operation
- FSM states are `IDLE`, `CALC`, `FIXUP`. Reset puts it in `IDLE`.
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, counter=0.
- Accept condition is `start & ~busy & ~flush`. On acceptance the block latches the op and the operand magnitudes: absolute value for signed ops, raw value for unsigned ops. It also latches the sign-fix flags and the divide-by-zero flag, clears the accumulator, and enters `CALC` with counter=0.
- `CALC` runs one iteration per cycle. Multiply is shift-add into a 2×WIDTH accumulator. Divide is restoring shift-subtract producing quotient and remainder. The counter increments each cycle, and after WIDTH iterations the FSM moves to `FIXUP`.
- `FIXUP` applies the sign fix:
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Writes HI = product[63:32] or remainder, and LO = product[31:0] or quotient.
  - Pulses `done`, clears `busy`, returns to `IDLE`.
- Divide by zero runs the full latency and produces LO=all-ones and HI=raw `rs_data`, with no sign fix.
- DIV of 0x80000000 by 0xFFFFFFFF gives LO=0x80000000, HI=0.
- `hi_we`/`lo_we` in `IDLE` write `wdata` at the edge. While busy they are not applied and `stall` holds them off.
- `flush` in `CALC`/`FIXUP` returns the FSM to `IDLE` at the next edge. HI/LO are unchanged, no `done` pulse is produced, and `busy` drops.
- `flush` in `IDLE` blocks acceptance that cycle.
- `stall` = `busy & (start | hilo_rd | hi_we | lo_we)`.
- `reset_n` low at any time, including mid-`CALC`, forces the reset values immediately, independent of `clk`.

## Timing
- Edge E0 accepts the op. Edges E1–E32 perform the iterations. Edge E33 performs `FIXUP`.
- `busy` is high from after E0 through E33, i.e. 33 cycles.
- `done` and the new HI/LO are visible after E33, in the same cycle that `busy` returns to 0.
- `hilo_rd` in the `done` cycle sees the new values with no stall.
- A `start` in the `done` cycle is accepted, giving back-to-back issue with a 34-cycle period.
- `stall` is combinational from inputs and the registered `busy`. There is no combinational path from `start` to `busy`.
- `done` is never high while `busy` is high.

## Structure
- Shared package `muldiv_pkg` holds:
  - `md_op_t` (2 bits) and the `MD_*` constants.
  - `md_state_t` (`IDLE`, `CALC`, `FIXUP`).
  - `MD_ITER` = 32.
- One sub-module is natural: `muldiv_step`, a combinational single-iteration unit. It takes the op class, accumulator and operand, and returns the next accumulator.
- The FSM, counter, sign handling and HI/LO registers stay in `muldiv_sequencer`.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF gives HI=0xFFFFFFFE, LO=0x00000001. `done` occurs exactly 34 edges after `start` was asserted with `busy`=0.
- MULT −3 × 7 gives HI=0xFFFFFFFF, LO=0xFFFFFFEB. A back-to-back DIVU 100 / 7 issued in the `done` cycle gives LO=14, HI=2.
- DIV −7 / 2 gives LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIV 0x12345678 / 0 gives LO=0xFFFFFFFF, HI=0x12345678 after the full 33-cycle `busy`.
- During `busy`, assert `hilo_rd`, then `hi_we` with 0xAAAA5555, then `start`. `stall`=1 for each. After `done`, the `hi_we` lands and `hi`=0xAAAA5555. The held `start` is accepted in the `done` cycle.
- `flush` at iteration 10 leaves HI/LO at their prior values, produces no `done`, and drops `busy` next cycle. `reset_n` low at iteration 20 clears `hi`, `lo`, `busy` and `done` immediately, with no clock edge.
